// File: rtl/my_bus_arbiter_4_way.sv
// Four-way round-robin bus arbiter with a registered grant/select and a gated
// 16-bit output mux. MAX_HOLD bounds how long one requester may keep the bus
// while others wait (0 = unlimited).
// Optional build macro ARB_LOCK_EN adds a lock input that suppresses forced
// rotation while a grant is active.
module my_bus_arbiter_4_way #(
    parameter int unsigned MAX_HOLD = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  req,
`ifdef ARB_LOCK_EN
    input  logic        lock,
`endif
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic [15:0] c,
    input  logic [15:0] d,
    output logic [3:0]  grant,
    output logic [1:0]  sel,
    output logic [15:0] out,
    output logic        out_valid
);

    localparam int unsigned CW = (MAX_HOLD == 0) ? 1 : $clog2(MAX_HOLD + 1);
    localparam logic [CW-1:0] HOLD_MAX = CW'(MAX_HOLD);
    localparam logic [CW-1:0] HOLD_ONE = CW'(1);

    typedef enum logic {StIdle, StBusy} state_t;

    state_t          state_q, state_d;
    logic [3:0]      grant_q, grant_d;
    logic [1:0]      sel_q, sel_d;
    logic [1:0]      ptr_q, ptr_d;
    logic [CW-1:0]   hold_q, hold_d;
    logic [3:0]      others;
    logic [1:0]      first_idx;
    logic [1:0]      next_idx;
    logic            locked;

`ifdef ARB_LOCK_EN
    assign locked = lock;
`else
    assign locked = 1'b0;
`endif

    // First set bit of r scanning start, start+1, ... modulo 4.
    function automatic logic [1:0] rr_pick(input logic [3:0] r, input logic [1:0] start);
        logic [1:0] idx;
        rr_pick = start;
        // Descending scan so the smallest offset from start wins.
        for (int i = 3; i >= 0; i--) begin
            idx = start + 2'(i);
            if (r[idx]) rr_pick = idx;
        end
    endfunction

    // Arbitration state: grant, select, round-robin pointer and hold counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
            grant_q <= 4'b0000;
            sel_q   <= 2'd0;
            ptr_q   <= 2'd0;
            hold_q  <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            sel_q   <= sel_d;
            ptr_q   <= ptr_d;
            hold_q  <= hold_d;
        end
    end

    // Next-state: initial grant from idle, release handoff, forced rotation, hold.
    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        sel_d     = sel_q;
        ptr_d     = ptr_q;
        hold_d    = hold_q;
        // In BUSY grant_q is the one-hot of sel_q, so this masks the current owner.
        others    = req & ~grant_q;
        first_idx = rr_pick(req, ptr_q);
        next_idx  = rr_pick(others, sel_q + 2'd1);
        unique case (state_q)
            StIdle: begin
                if (|req) begin
                    state_d = StBusy;
                    grant_d = 4'b0001 << first_idx;
                    sel_d   = first_idx;
                    hold_d  = HOLD_ONE;
                end
            end
            StBusy: begin
                if (!req[sel_q]) begin
                    ptr_d = sel_q + 2'd1;
                    if (|others) begin
                        grant_d = 4'b0001 << next_idx;
                        sel_d   = next_idx;
                        hold_d  = HOLD_ONE;
                    end else begin
                        grant_d = 4'b0000;
                        state_d = StIdle;
                    end
                end else if ((MAX_HOLD != 0) && !locked && (hold_q == HOLD_MAX) && (|others)) begin
                    grant_d = 4'b0001 << next_idx;
                    sel_d   = next_idx;
                    ptr_d   = sel_q + 2'd1;
                    hold_d  = HOLD_ONE;
                end else if ((MAX_HOLD != 0) && (hold_q != HOLD_MAX)) begin
                    hold_d = hold_q + HOLD_ONE;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Output mux driven only from registered select/grant.
    always_comb begin
        out = 16'h0000;
        if (out_valid) begin
            unique case (sel_q)
                2'd0: out = a;
                2'd1: out = b;
                2'd2: out = c;
                2'd3: out = d;
                default: out = 16'h0000;
            endcase
        end
    end

    assign grant     = grant_q;
    assign sel       = sel_q;
    assign out_valid = |grant_q;

endmodule

// File: tb/tb_my_bus_arbiter_4_way.sv
// Directed self-checking bench for my_bus_arbiter_4_way. Instances with
// MAX_HOLD=4 and MAX_HOLD=0 share stimulus; with ARB_LOCK_EN a MAX_HOLD=2
// instance with lock is added.
module tb_my_bus_arbiter_4_way;

    logic        clk;
    logic        reset;
    logic [3:0]  req;
    logic [15:0] a, b, c, d;
`ifdef ARB_LOCK_EN
    logic        lock;
    logic [3:0]  grantl;
    logic [1:0]  sell;
    logic [15:0] outl;
    logic        validl;
`endif
    logic [3:0]  grant, grant0;
    logic [1:0]  sel, sel0;
    logic [15:0] out, out0;
    logic        out_valid, valid0;

    int compared;
    int mismatched;

    my_bus_arbiter_4_way #(.MAX_HOLD(4)) dut (
        .clk(clk), .reset(reset), .req(req),
`ifdef ARB_LOCK_EN
        .lock(1'b0),
`endif
        .a(a), .b(b), .c(c), .d(d),
        .grant(grant), .sel(sel), .out(out), .out_valid(out_valid)
    );

    my_bus_arbiter_4_way #(.MAX_HOLD(0)) dut0 (
        .clk(clk), .reset(reset), .req(req),
`ifdef ARB_LOCK_EN
        .lock(1'b0),
`endif
        .a(a), .b(b), .c(c), .d(d),
        .grant(grant0), .sel(sel0), .out(out0), .out_valid(valid0)
    );

`ifdef ARB_LOCK_EN
    my_bus_arbiter_4_way #(.MAX_HOLD(2)) dutl (
        .clk(clk), .reset(reset), .req(req), .lock(lock),
        .a(a), .b(b), .c(c), .d(d),
        .grant(grantl), .sel(sell), .out(outl), .out_valid(validl)
    );
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        req   = 4'b0000;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        #3;
        compared++;
        if (grant !== 4'b0000 || sel !== 2'd0 || out !== 16'h0000 || out_valid !== 1'b0) begin
            mismatched++;
            $display("FAIL reset_state got grant=%b sel=%0d out=%h valid=%b exp 0000/0/0000/0",
                     grant, sel, out, out_valid);
        end
        do_reset();
        // Mid-grant asynchronous reset.
        req = 4'b0010;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            compared++;
            if (grant !== 4'b0010) begin
                mismatched++;
                $display("FAIL rst_pre_grant cycle %0d got %b exp 0010", i, grant);
            end
        end
        reset = 1'b1;
        #1;
        compared++;
        if (grant !== 4'b0000 || out_valid !== 1'b0 || out !== 16'h0000) begin
            mismatched++;
            $display("FAIL rst_mid_grant got grant=%b valid=%b out=%h exp 0000/0/0000",
                     grant, out_valid, out);
        end
        reset = 1'b0;
        req   = 4'b0001;
        @(posedge clk); #1;
        compared++;
        if (grant !== 4'b0001) begin
            mismatched++;
            $display("FAIL rst_after_release got %b exp 0001", grant);
        end
    endtask

    task automatic test_single();
        do_reset();
        a   = 16'hBEEF;
        req = 4'b0001;
        @(posedge clk); #1;
        compared++;
        if (grant !== 4'b0001 || sel !== 2'd0 || out !== 16'hBEEF || out_valid !== 1'b1) begin
            mismatched++;
            $display("FAIL single_grant got grant=%b sel=%0d out=%h valid=%b exp 0001/0/beef/1",
                     grant, sel, out, out_valid);
        end
        req = 4'b0000;
        @(posedge clk); #1;
        compared++;
        if (grant !== 4'b0000 || out !== 16'h0000 || out_valid !== 1'b0) begin
            mismatched++;
            $display("FAIL single_release got grant=%b out=%h valid=%b exp 0000/0000/0",
                     grant, out, out_valid);
        end
    endtask

    task automatic test_round_robin();
        logic [3:0]  req_v [5];
        logic [3:0]  exp_g [5];
        logic [15:0] exp_o [5];
        req_v[0] = 4'b1111; exp_g[0] = 4'b0001; exp_o[0] = 16'h1111;
        req_v[1] = 4'b1110; exp_g[1] = 4'b0010; exp_o[1] = 16'h2222;
        req_v[2] = 4'b1101; exp_g[2] = 4'b0100; exp_o[2] = 16'h3333;
        req_v[3] = 4'b1011; exp_g[3] = 4'b1000; exp_o[3] = 16'h4444;
        req_v[4] = 4'b0111; exp_g[4] = 4'b0001; exp_o[4] = 16'h1111;
        do_reset();
        a = 16'h1111; b = 16'h2222; c = 16'h3333; d = 16'h4444;
        for (int i = 0; i < 5; i++) begin
            req = req_v[i];
            @(posedge clk); #1;
            compared++;
            if (grant !== exp_g[i] || out !== exp_o[i] || out_valid !== 1'b1) begin
                mismatched++;
                $display("FAIL round_robin step %0d got grant=%b out=%h valid=%b exp %b/%h/1",
                         i, grant, out, out_valid, exp_g[i], exp_o[i]);
            end
        end
    endtask

    task automatic test_forced_rotation();
        do_reset();
        a = 16'h1111; c = 16'h3333;
        req = 4'b0001;
        for (int i = 1; i <= 4; i++) begin
            @(posedge clk); #1;
            compared++;
            if (grant !== 4'b0001) begin
                mismatched++;
                $display("FAIL rotate_hold cycle %0d got %b exp 0001", i, grant);
            end
            if (i == 1) req = 4'b0101;
        end
        @(posedge clk); #1;
        compared++;
        if (grant !== 4'b0100 || sel !== 2'd2 || out !== 16'h3333) begin
            mismatched++;
            $display("FAIL rotate_to_c got grant=%b sel=%0d out=%h exp 0100/2/3333",
                     grant, sel, out);
        end
        req = 4'b0001;
        @(posedge clk); #1;
        compared++;
        if (grant !== 4'b0001) begin
            mismatched++;
            $display("FAIL rotate_back_a got %b exp 0001", grant);
        end
    endtask

    task automatic test_unlimited_hold();
        int bad;
        do_reset();
        a = 16'h1111; d = 16'hD00D;
        req = 4'b1000;
        @(posedge clk); #1;
        compared++;
        if (grant0 !== 4'b1000 || out0 !== 16'hD00D) begin
            mismatched++;
            $display("FAIL unlim_first got grant=%b out=%h exp 1000/d00d", grant0, out0);
        end
        req = 4'b1001;
        bad = 0;
        for (int i = 0; i < 50; i++) begin
            @(posedge clk); #1;
            if (grant0 !== 4'b1000 && bad == 0) begin
                bad = 1;
                $display("FAIL unlim_hold cycle %0d got %b exp 1000", i, grant0);
            end
        end
        compared++;
        if (bad != 0) mismatched++;
        req = 4'b0001;
        @(posedge clk); #1;
        compared++;
        if (grant0 !== 4'b0001 || sel0 !== 2'd0 || valid0 !== 1'b1) begin
            mismatched++;
            $display("FAIL unlim_handoff got grant=%b sel=%0d valid=%b exp 0001/0/1",
                     grant0, sel0, valid0);
        end
    endtask

`ifdef ARB_LOCK_EN
    task automatic test_lock();
        do_reset();
        lock = 1'b1;
        req  = 4'b0011;
        @(posedge clk); #1;
        compared++;
        if (grantl !== 4'b0001) begin
            mismatched++;
            $display("FAIL lock_first got %b exp 0001", grantl);
        end
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            compared++;
            if (grantl !== 4'b0001) begin
                mismatched++;
                $display("FAIL lock_hold cycle %0d got %b exp 0001", i, grantl);
            end
        end
        lock = 1'b0;
        @(posedge clk); #1;
        compared++;
        if (grantl !== 4'b0010) begin
            mismatched++;
            $display("FAIL lock_release got %b exp 0010", grantl);
        end
    endtask
`endif

    initial begin
        compared   = 0;
        mismatched = 0;
        req = 4'b0000;
        a = 16'h0; b = 16'h0; c = 16'h0; d = 16'h0;
`ifdef ARB_LOCK_EN
        lock = 1'b0;
`endif
        test_reset();
        test_single();
        test_round_robin();
        test_forced_rotation();
        test_unlimited_hold();
`ifdef ARB_LOCK_EN
        test_lock();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/my_bus_arbiter_4_way.md
Name: my_bus_arbiter_4_way

Overview:
- Round-robin arbiter that shares one 16-bit 4-way mux datapath between four requesters (a, b, c, d).
- Owns the mux select: it decides which requester's data drives the shared bus, and for how long.
- Registers the grant and select, then gates the muxed data onto out with a valid flag.
- Sits between the four bus masters and the downstream 16-bit consumer.

Parameters:
- MAX_HOLD, 8: maximum consecutive cycles one requester may hold the grant while others wait. 0 means unlimited (release only on req drop).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- req  input  4  request lines; bit 0=a, 1=b, 2=c, 3=d. Held high while the requester wants the bus.
- a  input  16  requester 0 data.
- b  input  16  requester 1 data.
- c  input  16  requester 2 data.
- d  input  16  requester 3 data.
- grant  output  4  one-hot registered grant, or 0 when idle.
- sel  output  2  registered mux select (index of granted requester).
- out  output  16  selected data when out_valid=1, else 16'h0000.
- out_valid  output  1  high while any grant is active.

Behaviour:
- Reset (async, immediate, including mid-grant):
  - grant=0, sel=0, out_valid=0, out=0.
  - State IDLE, round-robin pointer ptr=0, hold_cnt=0.
- State IDLE:
  - On an edge with req!=0, grant the first set req bit scanning ptr, ptr+1, ... modulo 4.
  - Grant is registered, so latency is 1 cycle from req to grant/out_valid.
  - sel=index, hold_cnt=1, go to BUSY.
  - req=0 keeps IDLE; sel holds its last value.
- State BUSY (g = sel):
  - Release (req[g]=0 at edge):
    - ptr=g+1 mod 4.
    - If any other req is set, grant the next one after g in cyclic order on the same edge (no dead cycle), hold_cnt=1.
    - Otherwise grant=0 and return to IDLE.
  - Forced rotation (req[g]=1, MAX_HOLD!=0, hold_cnt==MAX_HOLD, some other req set):
    - Grant the next requester after g, ptr=g+1, hold_cnt=1.
    - The preempted requester keeps req high and re-competes in normal round-robin order.
  - Hold (req[g]=1, no rotation):
    - grant unchanged.
    - hold_cnt increments, saturating at MAX_HOLD; with no other req, the grant persists indefinitely.
    - A competing req arriving after saturation rotates on the next edge.
- Datapath:
  - out = (a, b, c, d)[sel] when out_valid, else 0. Combinational from registered sel/grant only; no req-to-out combinational path.
  - out_valid = |grant.
- Invariants:
  - grant is always 0 or exactly one-hot.
  - grant[sel]==1 whenever out_valid.
  - The request-to-grant wait is bounded by 3*MAX_HOLD+1 cycles when MAX_HOLD!=0.
- Widths:
  - hold_cnt is $clog2(MAX_HOLD+1) bits, minimum 1.
  - ptr is 2 bits and wraps 3->0.

Optional Feature:
- Macro: ARB_LOCK_EN.
- Defined:
  - Adds input lock (1 bit), placed after req.
  - While lock=1 and out_valid=1, forced rotation is suppressed and hold_cnt saturates.
  - Release on req[g]=0 still works.
  - lock is ignored in IDLE.
- Undefined:
  - No lock port; forced rotation behaves as described above.

Test Plan:
- Reset mid-grant: req=4'b0010 for 3 cycles, then assert reset -> grant=0, out_valid=0, out=16'h0000 in the same cycle. After release, req=4'b0001 yields grant=4'b0001 (ptr back at 0).
- Single request: a=16'hBEEF, req=4'b0001 -> cycle+1: grant=4'b0001, sel=0, out=16'hBEEF, out_valid=1. Drop req -> next cycle grant=0, out=0.
- Round robin, all requesting and each releasing after 1 cycle of grant (req=4'hF, each req bit dropped then re-raised) -> grants in order 0001, 0010, 0100, 1000, 0001 with no idle cycles between.
- Forced rotation, MAX_HOLD=4: req=4'b0001 held, req[2] raised at cycle 2 -> grant=0001 for 4 cycles, then 0100. After c releases, grant returns to 0001.
- Unlimited hold, MAX_HOLD=0: req=4'b1000 held 50 cycles with req[0] also set -> grant stays 1000 until req[3] drops, then 0001 on the same edge.
- ARB_LOCK_EN, MAX_HOLD=2: lock=1 with req=4'b0011 and grant 0001 -> grant stays 0001 for 10 cycles. Drop lock -> rotates to 0010 on the next edge.
